// File: rtl/sat_itl_frame_ctrl.sv
// Frame sequencer for the SAT-downlink interleaver RAM: fill one frame, then drain it.
// Optional status ports (frame_cnt, err_sticky) under `define SAT_ITL_CTRL_STATUS_EN.
module sat_itl_frame_ctrl #(
  parameter int A_WIDTH   = 16,
  parameter int FRAME_LEN = 4096,
  parameter int LAT_STD   = 2,
  parameter int LAT_DITL  = 3
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [15:0]        id_offset_i,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               in_ready,
  output logic               ram_wen,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic               ram_wdata,
  output logic [15:0]        ram_id_off,
  input  logic               ram_rdata,
  input  logic               ram_rd_itl,
  input  logic               ram_rd_ditl,
  output logic               out_valid,
  output logic               out_data,
  output logic               out_last,
  output logic               busy
`ifdef SAT_ITL_CTRL_STATUS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic               err_sticky
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    FLUSH
  } state_t;

  localparam logic [A_WIDTH:0] LAST = (A_WIDTH+1)'(FRAME_LEN - 1);

  state_t               state;
  state_t               state_n;
  logic [A_WIDTH:0]     cnt;
  logic [A_WIDTH:0]     cnt_n;
  logic [1:0]           mode_q;
  logic [15:0]          id_q;
  logic [LAT_DITL:1]    vld_sr;
  logic [LAT_DITL:1]    last_sr;
  logic [A_WIDTH-1:0]   waddr_q;
  logic                 wr;
  logic                 issue;
  logic                 accept;
  logic                 sel_ditl;
  logic                 src;

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr      = 1'b0;
    issue   = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = FILL;
          cnt_n   = '0;
        end
      end
      FILL: begin
        if (in_valid) begin
          wr = 1'b1;
          if (cnt == LAST) begin
            state_n = DRAIN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        issue = 1'b1;
        if (cnt == LAST) begin
          state_n = FLUSH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      FLUSH: begin
        // leave once the final issue slot shifts out on this edge
        if (vld_sr[LAT_DITL-1:1] == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt     <= '0;
      mode_q  <= '0;
      id_q    <= '0;
      vld_sr  <= '0;
      last_sr <= '0;
      waddr_q <= '0;
    end else begin
      cnt <= cnt_n;
      if (accept) begin
        mode_q <= mode;
        id_q   <= id_offset_i;
      end
      vld_sr  <= {vld_sr[LAT_DITL-1:1], issue};
      last_sr <= {last_sr[LAT_DITL-1:1], issue && (cnt == LAST)};
      waddr_q <= ram_waddr;
    end
  end

  assign in_ready   = (state == FILL);
  assign busy       = (state != IDLE);
  assign ram_wen    = wr;
  assign ram_wdata  = wr & in_data;
  assign ram_waddr  = (wr || issue) ? cnt[A_WIDTH-1:0] : waddr_q;
  assign ram_id_off = id_q;

  // mode 3 is reserved and behaves as original order
  assign sel_ditl  = (mode_q == 2'd2);
  assign src       = (mode_q == 2'd1) ? ram_rd_itl
                   : sel_ditl         ? ram_rd_ditl
                   :                    ram_rdata;
  assign out_valid = sel_ditl ? vld_sr[LAT_DITL]  : vld_sr[LAT_STD];
  assign out_last  = sel_ditl ? last_sr[LAT_DITL] : last_sr[LAT_STD];
  assign out_data  = out_valid & src;

`ifdef SAT_ITL_CTRL_STATUS_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      frame_cnt  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (out_last) frame_cnt <= frame_cnt + 16'd1;
      if ((in_valid && state != FILL) || (start && state != IDLE))
        err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sat_itl_frame_ctrl.sv
// Directed bench for sat_itl_frame_ctrl with an 8-bit frame and a behavioural ram_dual.
// Status port checks compile in when SAT_ITL_CTRL_STATUS_EN is defined.
module tb_sat_itl_frame_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] id_offset_i;
  logic        in_valid;
  logic        in_data;
  logic        in_ready;
  logic        ram_wen;
  logic [2:0]  ram_waddr;
  logic        ram_wdata;
  logic [15:0] ram_id_off;
  logic        ram_rdata;
  logic        ram_rd_itl;
  logic        ram_rd_ditl;
  logic        out_valid;
  logic        out_data;
  logic        out_last;
  logic        busy;
`ifdef SAT_ITL_CTRL_STATUS_EN
  logic [15:0] frame_cnt;
  logic        err_sticky;
`endif

  sat_itl_frame_ctrl #(
    .A_WIDTH  (3),
    .FRAME_LEN(8),
    .LAT_STD  (2),
    .LAT_DITL (3)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .mode       (mode),
    .id_offset_i(id_offset_i),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_wen    (ram_wen),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_id_off (ram_id_off),
    .ram_rdata  (ram_rdata),
    .ram_rd_itl (ram_rd_itl),
    .ram_rd_ditl(ram_rd_ditl),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
`ifdef SAT_ITL_CTRL_STATUS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_sticky (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  // ram_dual model: identity or reversed permutation
  logic       rev = 1'b0;
  logic       mem [8];
  logic [2:0] a1, a2, a3;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    a1 <= ram_waddr;
    a2 <= a1;
    a3 <= a2;
  end

  assign ram_rdata   = mem[a2];
  assign ram_rd_itl  = mem[rev ? 3'd7 - a2 : a2];
  assign ram_rd_ditl = mem[rev ? 3'd7 - a3 : a3];

  int   cyc = 0;
  logic bit_q [$];
  int   vcyc_q[$];
  int   last_q[$];
  int   wcyc_q[$];
  int   wadr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      if (out_last) last_q.push_back(bit_q.size());
      bit_q.push_back(out_data);
      vcyc_q.push_back(cyc);
    end
    if (ram_wen) begin
      wcyc_q.push_back(cyc);
      wadr_q.push_back(int'(ram_waddr));
    end
  end

  int total = 0;
  int bad   = 0;
  int bv, bw, bl;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    bv = bit_q.size();
    bw = wcyc_q.size();
    bl = last_q.size();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  // mode/id are disturbed right after the start pulse; they must not matter
  task automatic kick(input logic [1:0] m, input logic [15:0] id);
    mode        = m;
    id_offset_i = id;
    start       = 1'b1;
    step();
    start       = 1'b0;
    mode        = 2'd3;
    id_offset_i = 16'hFFFF;
  endtask

  task automatic feed(input logic [7:0] b, input bit gap);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = b[i];
      step();
      if (gap) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    in_data  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && busy; k++) step();
    chk(tag, busy, 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp,
                             input int lat);
    logic [7:0] got;
    int         nbad;
    got  = '0;
    nbad = 0;
    chk({tag, "_nwen"}, wcyc_q.size() - bw, 8);
    for (int i = 0; i < 8; i++)
      if (bw + i < wadr_q.size() && wadr_q[bw+i] != i) nbad++;
    chk({tag, "_waddr"}, nbad, 0);
    chk({tag, "_nout"}, bit_q.size() - bv, 8);
    for (int i = 0; i < 8; i++)
      if (bv + i < bit_q.size()) got[i] = bit_q[bv+i];
    chk({tag, "_data"}, got, exp);
    if (bit_q.size() - bv >= 8 && wcyc_q.size() - bw >= 8) begin
      chk({tag, "_lat"}, vcyc_q[bv] - wcyc_q[bw+7], lat + 1);
      chk({tag, "_contig"}, vcyc_q[bv+7] - vcyc_q[bv], 7);
    end
    chk({tag, "_nlast"}, last_q.size() - bl, 1);
    if (last_q.size() > bl) chk({tag, "_lastpos"}, last_q[bl], bv + 7);
  endtask

  initial begin
    n_rst       = 1'b0;
    start       = 1'b0;
    mode        = 2'd0;
    id_offset_i = 16'h0;
    in_valid    = 1'b0;
    in_data     = 1'b0;
    do_reset();

    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_wen", ram_wen, 1'b0);
    chk("rst_waddr", ram_waddr, 3'd0);
    chk("rst_idoff", ram_id_off, 16'h0);
    chk("rst_oval", out_valid, 1'b0);
    chk("rst_olast", out_last, 1'b0);
`ifdef SAT_ITL_CTRL_STATUS_EN
    chk("rst_fcnt", frame_cnt, 16'h0);
    chk("rst_err", err_sticky, 1'b0);
`endif

    // original order, back-to-back input
    snap();
    kick(2'd0, 16'h00A5);
    chk("f1_ready", in_ready, 1'b1);
    chk("f1_idoff", ram_id_off, 16'h00A5);
    feed(8'b0100_1101, 1'b0);
    chk("f1_drain_ready", in_ready, 1'b0);
    wait_idle("f1_idle");
    check_frame("f1", 8'b0100_1101, 2);
    chk("f1_waddr_hold", ram_waddr, 3'd7);

    // reversed permutation through interleaved and deinterleaved taps
    rev = 1'b1;
    snap();
    kick(2'd1, 16'h0001);
    feed(8'b0100_1101, 1'b0);
    wait_idle("f2i_idle");
    check_frame("f2i", 8'b1011_0010, 2);

    snap();
    kick(2'd2, 16'h0002);
    feed(8'b0100_1101, 1'b0);
    wait_idle("f2d_idle");
    check_frame("f2d", 8'b1011_0010, 3);
    rev = 1'b0;

    // gapped input
    snap();
    kick(2'd0, 16'h0003);
    feed(8'b1110_0101, 1'b1);
    wait_idle("f3_idle");
    check_frame("f3", 8'b1110_0101, 2);
`ifdef SAT_ITL_CTRL_STATUS_EN
    chk("f3_err", err_sticky, 1'b0);
`endif

    // start during DRAIN and in_valid during FLUSH
    snap();
    kick(2'd0, 16'h0004);
    feed(8'b0011_1001, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("f4_flush_busy", busy, 1'b1);
    in_valid = 1'b1;
    in_data  = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 1'b0;
    wait_idle("f4_idle");
    repeat (4) step();
    chk("f4_no_restart", busy, 1'b0);
    check_frame("f4", 8'b0011_1001, 2);
`ifdef SAT_ITL_CTRL_STATUS_EN
    chk("f4_err", err_sticky, 1'b1);
    chk("f4_fcnt", frame_cnt, 16'd5);
`endif

    // reset at the fifth FILL write
    kick(2'd0, 16'h0055);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 1'b1;
      step();
    end
    snap();
    in_valid = 1'b1;
    n_rst    = 1'b0;
    step();
    n_rst    = 1'b1;
    in_valid = 1'b0;
    in_data  = 1'b0;
    chk("r5_busy", busy, 1'b0);
    chk("r5_ready", in_ready, 1'b0);
    chk("r5_wen", ram_wen, 1'b0);
    chk("r5_waddr", ram_waddr, 3'd0);
    chk("r5_idoff", ram_id_off, 16'h0);
    repeat (12) step();
    chk("r5_nout", bit_q.size() - bv, 0);
    chk("r5_nlast", last_q.size() - bl, 0);
`ifdef SAT_ITL_CTRL_STATUS_EN
    chk("r5_err", err_sticky, 1'b0);
`endif
    snap();
    kick(2'd0, 16'h0006);
    feed(8'b1000_0001, 1'b0);
    wait_idle("r5f_idle");
    check_frame("r5f", 8'b1000_0001, 2);

    // three frames back-to-back after a clean reset
    do_reset();
    snap();
    for (int f = 0; f < 3; f++) begin
      kick(2'd0, 16'h0010);
      feed(8'b0101_1010, 1'b0);
      wait_idle("b6_idle");
    end
    chk("b6_idoff", ram_id_off, 16'h0010);
    chk("b6_nout", bit_q.size() - bv, 24);
    chk("b6_nlast", last_q.size() - bl, 3);
`ifdef SAT_ITL_CTRL_STATUS_EN
    chk("b6_fcnt", frame_cnt, 16'd3);
    chk("b6_err", err_sticky, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
